// File: rtl/jio_pkg.sv
// jio_pkg - shared definitions for the jioctl IO controller.
//   ST_*      : bit positions of the per-channel status byte.
//   strobe_e  : decoded CPU strobe operation.
//   jio_decode: maps (io_s, io_e, io_da, io_io) to a strobe_e value.
//               Any ambiguous combination (both strobes, or a direction
//               that does not fit the strobe) decodes to NONE.
package jio_pkg;

    localparam int ST_HOLDV = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [2:0] {
        NONE,
        ADDR_SEL,
        DATA_WR,
        DATA_RD,
        STAT_RD
    } strobe_e;

    function automatic strobe_e jio_decode(input logic s, input logic e,
                                           input logic da, input logic io);
        strobe_e op;
        op = NONE;
        if (s && !e && io)
            op = da ? ADDR_SEL : DATA_WR;
        else if (e && !s && !io)
            op = da ? STAT_RD : DATA_RD;
        return op;
    endfunction

endpackage

// File: rtl/jfifo.sv
// jfifo - single-clock FIFO used as one jioctl output channel.
//   CLK, RSTN   : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata : write request and data; refused when full unless a pop
//                 happens on the same edge
//   pop         : read request; ignored when empty
//   head        : current head entry (combinational from storage, so a
//                 pushed word is visible the cycle after the push)
//   full, empty : occupancy flags
module jfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);

    // A pop frees the slot the push needs, so push on full is legal when
    // popping; pop on empty never happens, so a push on empty is push-only.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign head = mem[rd_ptr_reg];

    // Storage is not reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr_reg] <= wdata;
    end

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/jioctl.sv
// jioctl - CPU-bus IO controller with NDEV device channels.
//   CLK, RSTN            : clock, asynchronous active-low reset
//   bus_in / bus_out     : CPU bus; bus_out is 0 unless a read is decoded
//   io_s, io_e           : set (write/select) and enable (read) strobes
//   io_da, io_io         : address/status vs data, output vs input
//   dev_data/dev_valid/dev_ready : per-channel output FIFO handshake
//   in_data/in_valid/in_ready    : per-channel input capture handshake
// Build option: macro JIOCTL_INPUT_EN includes the input capture path;
// without it in_ready is 0, data reads return 0 and the hold_v status bit
// reads 0.
module jioctl
    import jio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NDEV  = 4,
    parameter int DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [WIDTH-1:0]      bus_in,
    output logic [WIDTH-1:0]      bus_out,
    input  logic                  io_s,
    input  logic                  io_e,
    input  logic                  io_da,
    input  logic                  io_io,
    output logic [NDEV*WIDTH-1:0] dev_data,
    output logic [NDEV-1:0]       dev_valid,
    input  logic [NDEV-1:0]       dev_ready,
    input  logic [NDEV*WIDTH-1:0] in_data,
    input  logic [NDEV-1:0]       in_valid,
    output logic [NDEV-1:0]       in_ready
);
    localparam int CW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam logic [WIDTH-1:0] NDEV_W = WIDTH'(NDEV);

    strobe_e          op;
    logic [WIDTH-1:0] dev_addr_reg;
    logic             addr_ok;
    logic [CW-1:0]    sel;
    logic [NDEV-1:0]  ovf_reg;
    logic [NDEV-1:0]  fifo_push;
    logic [NDEV-1:0]  fifo_pop;
    logic [NDEV-1:0]  fifo_full;
    logic [NDEV-1:0]  fifo_empty;
    logic [NDEV-1:0]  hold_v;
    logic [WIDTH-1:0] fifo_head [NDEV];
    logic [WIDTH-1:0] bus_next;

    assign op      = jio_decode(io_s, io_e, io_da, io_io);
    // Out-of-range addresses select nothing: every per-channel action
    // below is qualified by addr_ok.
    assign addr_ok = (dev_addr_reg < NDEV_W);
    assign sel     = dev_addr_reg[CW-1:0];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            dev_addr_reg <= '0;
        else if (op == ADDR_SEL)
            dev_addr_reg <= bus_in;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NDEV; gi++) begin : g_chan
            assign fifo_push[gi] = (op == DATA_WR) && addr_ok && (sel == CW'(gi));
            assign fifo_pop[gi]  = dev_valid[gi] && dev_ready[gi];
            assign dev_valid[gi] = !fifo_empty[gi];
            assign dev_data[gi*WIDTH +: WIDTH] = fifo_head[gi];

            jfifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .CLK   (CLK),
                .RSTN  (RSTN),
                .push  (fifo_push[gi]),
                .wdata (bus_in),
                .pop   (fifo_pop[gi]),
                .head  (fifo_head[gi]),
                .full  (fifo_full[gi]),
                .empty (fifo_empty[gi])
            );
        end
    endgenerate

    // Overflow is only a dropped write: a full FIFO that pops on the same
    // edge takes the word, so it does not flag.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ovf_reg <= '0;
        end else begin
            for (int k = 0; k < NDEV; k++) begin
                if ((op == STAT_RD) && addr_ok && (sel == CW'(k)))
                    ovf_reg[k] <= 1'b0;
                else if (fifo_push[k] && fifo_full[k] && !fifo_pop[k])
                    ovf_reg[k] <= 1'b1;
            end
        end
    end

`ifdef JIOCTL_INPUT_EN
    logic [WIDTH-1:0] hold_reg [NDEV];
    logic [NDEV-1:0]  hold_v_reg;

    assign hold_v   = hold_v_reg;
    assign in_ready = ~hold_v_reg;

    // A read only clears a full holding register; since in_ready is low
    // then, the read-clear and a capture can never meet on one channel.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            hold_v_reg <= '0;
            for (int k = 0; k < NDEV; k++)
                hold_reg[k] <= '0;
        end else begin
            for (int k = 0; k < NDEV; k++) begin
                if ((op == DATA_RD) && addr_ok && (sel == CW'(k)) && hold_v_reg[k]) begin
                    hold_v_reg[k] <= 1'b0;
                end else if (in_valid[k] && !hold_v_reg[k]) begin
                    hold_v_reg[k] <= 1'b1;
                    hold_reg[k]   <= in_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end
`else
    logic unused_in;

    assign hold_v    = '0;
    assign in_ready  = '0;
    assign unused_in = ^{in_data, in_valid};
`endif

    always_comb begin
        bus_next = '0;
        if (addr_ok) begin
            case (op)
`ifdef JIOCTL_INPUT_EN
                DATA_RD: if (hold_v[sel]) bus_next = hold_reg[sel];
`endif
                STAT_RD: begin
                    bus_next[ST_HOLDV] = hold_v[sel];
                    bus_next[ST_EMPTY] = fifo_empty[sel];
                    bus_next[ST_FULL]  = fifo_full[sel];
                    bus_next[ST_OVF]   = ovf_reg[sel];
                end
                default: bus_next = '0;
            endcase
        end
    end

    // Forced low while in reset so the bus is quiet regardless of strobes.
    assign bus_out = RSTN ? bus_next : '0;

endmodule

// File: tb/tb_jioctl.sv
// tb_jioctl - directed plus randomized check of jioctl against a
// queue-based behavioural model of the controller.
module tb_jioctl;
    localparam int W = 8;
    localparam int N = 4;
    localparam int D = 4;
`ifdef JIOCTL_INPUT_EN
    localparam bit IN_EN = 1'b1;
`else
    localparam bit IN_EN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RSTN;
    logic [W-1:0]     bus_in;
    logic [W-1:0]     bus_out;
    logic             io_s, io_e, io_da, io_io;
    logic [N*W-1:0]   dev_data;
    logic [N-1:0]     dev_valid;
    logic [N-1:0]     dev_ready;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;

    jioctl #(.WIDTH(W), .NDEV(N), .DEPTH(D)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .io_s      (io_s),
        .io_e      (io_e),
        .io_da     (io_da),
        .io_io     (io_io),
        .dev_data  (dev_data),
        .dev_valid (dev_valid),
        .dev_ready (dev_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    logic [W-1:0] last_bus;

    // Behavioural model
    logic [W-1:0] mq [N][$];
    bit           movf [N];
    logic [W-1:0] mhold [N];
    bit           mhv [N];
    logic [W-1:0] maddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_rd_data();
        return io_e && !io_s && !io_da && !io_io;
    endfunction
    function automatic bit is_rd_stat();
        return io_e && !io_s && io_da && !io_io;
    endfunction
    function automatic bit is_wr();
        return io_s && !io_e && !io_da && io_io;
    endfunction
    function automatic bit is_sel();
        return io_s && !io_e && io_da && io_io;
    endfunction

    function automatic logic [W-1:0] model_bus();
        logic [W-1:0] r;
        int a;
        r = '0;
        if (maddr < N) begin
            a = int'(maddr);
            if (is_rd_data() && IN_EN && mhv[a])
                r = mhold[a];
            else if (is_rd_stat())
                r = {4'b0, movf[a], mq[a].size() == D, mq[a].size() == 0, IN_EN && mhv[a]};
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            movf[k] = 0; mhv[k] = 0; mhold[k] = '0;
        end
        maddr = '0;
    endtask

    task automatic model_edge();
        bit pk [N];
        bit ok, full_pre;
        int a;
        ok = (maddr < N);
        a  = ok ? int'(maddr) : 0;
        full_pre = ok && (mq[a].size() == D);
        for (int k = 0; k < N; k++) pk[k] = (mq[k].size() > 0) && dev_ready[k];
        for (int k = 0; k < N; k++) if (pk[k]) void'(mq[k].pop_front());
        if (ok && is_wr()) begin
            if (full_pre && !pk[a]) movf[a] = 1;
            else mq[a].push_back(bus_in);
        end
        if (ok && is_rd_stat()) movf[a] = 0;
        if (IN_EN) begin
            for (int k = 0; k < N; k++) begin
                if (ok && is_rd_data() && a == k && mhv[k]) mhv[k] = 0;
                else if (in_valid[k] && !mhv[k]) begin
                    mhv[k] = 1;
                    mhold[k] = in_data[k*W +: W];
                end
            end
        end
        if (is_sel()) maddr = bus_in;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance.
    task automatic tick();
        @(negedge CLK);
        last_bus = bus_out;
        chk("bus_out", bus_out, model_bus());
        for (int k = 0; k < N; k++) begin
            chk($sformatf("dev_valid[%0d]", k), dev_valid[k], mq[k].size() != 0);
            if (mq[k].size() != 0)
                chk($sformatf("dev_data[%0d]", k), dev_data[k*W +: W], mq[k][0]);
            chk($sformatf("in_ready[%0d]", k), in_ready[k], IN_EN && !mhv[k]);
        end
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic op(input logic s, input logic e, input logic da, input logic io,
                      input logic [W-1:0] b);
        io_s = s; io_e = e; io_da = da; io_io = io; bus_in = b;
        tick();
        io_s = 0; io_e = 0; io_da = 0; io_io = 0; bus_in = '0;
    endtask

    task automatic sel_addr(input logic [W-1:0] a); op(1, 0, 1, 1, a); endtask
    task automatic wr(input logic [W-1:0] d);       op(1, 0, 0, 1, d); endtask
    task automatic rd_stat();                       op(0, 1, 1, 0, '0); endtask
    task automatic rd_data();                       op(0, 1, 0, 0, '0); endtask
    task automatic idle();                          op(0, 0, 0, 0, '0); endtask

    initial begin
        RSTN = 0; bus_in = '0; io_s = 0; io_e = 0; io_da = 0; io_io = 0;
        dev_ready = '0; in_data = '0; in_valid = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RSTN = 1;

        // Reset state
        chk("rst_dev_valid", dev_valid, '0);
        chk("rst_in_ready", in_ready, IN_EN ? 4'hF : 4'h0);
        idle();

        // Basic write then drain on channel 2
        sel_addr(8'd2);
        wr(8'h41);
        wr(8'h42);
        idle();
        chk("ch2_valid", dev_valid[2], 1'b1);
        chk("ch2_head", dev_data[2*W +: W], 8'h41);
        dev_ready[2] = 1;
        tick();
        tick();
        dev_ready[2] = 0;
        chk("ch2_drained", dev_valid[2], 1'b0);

        // Overflow on channel 0
        sel_addr(8'd0);
        for (int i = 1; i <= 5; i++) wr(W'(i));
        rd_stat();
        chk("ovf_status", last_bus, 8'h0C);
        rd_stat();
        chk("ovf_cleared", last_bus, 8'h04);
        dev_ready[0] = 1;
        repeat (4) tick();
        dev_ready[0] = 0;
        chk("ch0_no_fifth", dev_valid[0], 1'b0);

        // Push into full FIFO while it pops
        sel_addr(8'd1);
        for (int i = 0; i < 4; i++) wr(8'h90 + W'(i));
        dev_ready[1] = 1;
        wr(8'h99);
        dev_ready[1] = 0;
        rd_stat();
        chk("full_pushpop_status", last_bus, 8'h04);
        dev_ready[1] = 1;
        repeat (4) tick();
        dev_ready[1] = 0;
        chk("ch1_drained", dev_valid[1], 1'b0);

        // Input capture on channel 3
        in_valid[3] = 1; in_data[3*W +: W] = 8'h7E;
        idle();
        in_valid[3] = 0;
        sel_addr(8'd3);
        rd_data();
`ifdef JIOCTL_INPUT_EN
        chk("in_read", last_bus, 8'h7E);
        chk("in_ready_back", in_ready[3], 1'b1);
        rd_data();
        chk("in_reread", last_bus, 8'h00);
`else
        chk("in_read_disabled", last_bus, 8'h00);
        chk("in_ready_disabled", in_ready[3], 1'b0);
`endif

        // Out-of-range address
        sel_addr(8'd9);
        wr(8'h55);
        rd_stat();
        chk("oob_status", last_bus, 8'h00);
        chk("oob_no_valid", dev_valid, '0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            dev_ready = 4'($urandom);
            in_valid  = 4'($urandom) & 4'($urandom);
            in_data   = $urandom;
            r = $urandom_range(0, 9);
            case (r)
                0:       sel_addr(W'($urandom_range(0, 5)));
                1, 2, 3: wr(W'($urandom));
                4:       rd_data();
                5:       rd_stat();
                6:       op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
                default: idle();
            endcase
        end
        dev_ready = '0; in_valid = '0;

        // Asynchronous reset with entries queued
        sel_addr(8'd3);
        wr(8'hA1); wr(8'hA2); wr(8'hA3);
        chk("pre_rst_valid", dev_valid[3], 1'b1);
        #2 RSTN = 0;
        #1;
        chk("rst_async_valid", dev_valid, '0);
        chk("rst_async_bus", bus_out, '0);
        model_reset();
        @(posedge CLK);
        #1 RSTN = 1;
        idle();
        idle();
        chk("post_rst_valid", dev_valid, '0);
        chk("post_rst_in_ready", in_ready, IN_EN ? 4'hF : 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jioctl.md
JIOCTL -- requirements
Module: jioctl

Interface
REQ-001 Parameter WIDTH, default 8: data/bus width in bits.
REQ-002 Parameter NDEV, default 4: number of device channels; range 1..16.
REQ-003 Parameter DEPTH, default 4: output FIFO entries per channel; power of two, at least 2.
REQ-004 CLK  in  1: sole clock; all state changes on rising edge.
REQ-005 RSTN  in  1: reset, asynchronous, active-low.
REQ-006 bus_in  in  WIDTH: CPU bus value.
REQ-007 bus_out  out  WIDTH: value driven onto CPU bus; zero when not enabled.
REQ-008 io_s, io_e  in  1 each: IO set / IO enable strobes.
REQ-009 io_da  in  1: 1 = address/status, 0 = data.
REQ-010 io_io  in  1: 1 = output (CPU to device), 0 = input.
REQ-011 dev_data  out  NDEV*WIDTH: output data; channel k at bits [k*WIDTH +: WIDTH].
REQ-012 dev_valid  out  NDEV; dev_ready  in  NDEV: output handshake, one bit per channel.
REQ-013 in_data  in  NDEV*WIDTH; in_valid  in  NDEV; in_ready  out  NDEV: input handshake, one bit per channel.

Function
REQ-014 Address select: on edge with io_s & io_da & io_io, dev_addr SHALL load bus_in.
REQ-015 dev_addr >= NDEV SHALL select no channel: writes are discarded, data and status reads return 0, no state changes.
REQ-016 Output write: on edge with io_s & !io_da & io_io, bus_in SHALL be pushed into the FIFO of channel dev_addr.
REQ-017 Write to a full FIFO SHALL be dropped and SHALL set that channel's sticky ovf bit, except as in REQ-019.
REQ-018 dev_valid[k] = FIFO k non-empty; dev_data[k] = head entry; pop on edge with dev_valid[k] & dev_ready[k]; first-word latency 1 cycle after push.
REQ-019 Simultaneous push and pop on a full FIFO SHALL accept the push, with no ovf; simultaneous push and pop on an empty FIFO SHALL push only.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; count range is 0..DEPTH.
REQ-021 Input capture: per channel, hold register plus hold_v; in_ready[k] = !hold_v[k]; on in_valid & in_ready, load in_data and set hold_v.
REQ-022 Data read: while io_e & !io_da & !io_io, bus_out = hold[dev_addr] when hold_v is set, else 0; on that edge hold_v[dev_addr] SHALL clear.
REQ-023 Status read: while io_e & io_da & !io_io, bus_out = {zeros, ovf, full, empty, hold_v} (bits 3..0) of channel dev_addr; on that edge ovf[dev_addr] SHALL clear.
REQ-024 Read clear and a new capture on the same edge: the clear takes priority; in_ready was low, so no capture can coincide.
REQ-025 io_s and io_e together, or any other strobe combination: bus_out = 0, no state change.

Reset
REQ-026 RSTN low SHALL immediately clear: dev_addr=0, all FIFOs empty, ovf=0, hold_v=0, hold=0, bus_out=0, dev_valid=0, in_ready=all ones (JIOCTL_INPUT_EN) or 0.
REQ-027 Reset mid-transfer SHALL discard FIFO contents with no partial pop; outputs are valid again the first edge after release.

Configuration
REQ-028 Macro JIOCTL_INPUT_EN defined: input path (REQ-021, REQ-022, REQ-024) present.
REQ-029 JIOCTL_INPUT_EN undefined: no hold registers; in_ready=0; data reads return 0; status hold_v bit=0; output path unchanged.

Structure
REQ-030 Package jio_pkg: status bit position constants (ST_HOLDV=0, ST_EMPTY=1, ST_FULL=2, ST_OVF=3) and the strobe-decode enumeration (ADDR_SEL, DATA_WR, DATA_RD, STAT_RD, NONE).
REQ-031 Sub-module jfifo (parameters WIDTH, DEPTH; push/pop/full/empty/head; async active-low reset), instantiated NDEV times via generate.

Verification
REQ-032 Select addr 2, write 0x41, 0x42 with dev_ready[2]=0 -> dev_valid[2]=1, dev_data[2]=0x41; raise ready for 2 cycles -> 0x41 then 0x42 pop; dev_valid[2] drops.
REQ-033 DEPTH=4, ready low, write 5 bytes to ch0 -> status read = 0x0C (ovf|full); second status read = 0x04; fifth byte is absent from the pops.
REQ-034 Full ch1, push while dev_ready[1]=1 -> push accepted, count stays 4, ovf=0.
REQ-035 in_valid[3] with in_data 0x7E, select 3, data read -> bus_out=0x7E, in_ready[3] returns 1 the next cycle; repeat read -> 0x00.
REQ-036 Select addr 9 (NDEV=4), write 0x55, read status -> bus_out=0, no dev_valid asserted.
REQ-037 RSTN pulsed low mid-stream with 3 entries queued -> dev_valid=0 immediately and stays 0 after release; rebuild without JIOCTL_INPUT_EN -> in_ready=0 and data read = 0.
